// File: rtl/pc_return_stack.sv
// Return-address stack for the program counter: circular buffer with a top pointer and occupancy count.
// Define PC_STACK_WRAP_EN to let a push while full overwrite the oldest entry instead of being dropped.
module pc_return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic             empty_w, full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FullCount);

    // The pointer always addresses the current top entry; a push lands one slot above it.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10: begin
                if (!full_w) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
`ifdef PC_STACK_WRAP_EN
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 1'b1;
`endif
                end
            end
            2'b01: begin
                if (empty_w) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d   = ptr_q - 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            2'b11: begin
                if (empty_w) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage needs no reset: q is forced to zero whenever the stack is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= d;
        end
    end

    assign q         = empty_w ? '0 : mem_q[ptr_q];
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
